// File: rtl/rv32imf_mem_pkg.sv
// Shared types and constants for the rv32imf memory responder.
package rv32imf_mem_pkg;

    // Response payload carried through the latency pipeline.
    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } mem_resp_t;

    // Read data returned for out-of-range accesses.
    localparam logic [31:0] RDATA_OOR = 32'hDEAD_BEEF;

endpackage

// File: rtl/rv32imf_resp_delay_line.sv
// Fixed-latency valid+payload shift register. Reset clears the valid bits only;
// the payload bits carry no meaning without a valid, so they are not reset.
module rv32imf_resp_delay_line
    import rv32imf_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 1,
    parameter type         T     = mem_resp_t
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic valid_i,
    input  T     data_i,
    output logic valid_o,
    output T     data_o
);

    logic valid_q [DEPTH];
    T     data_q  [DEPTH];

    // Valid pipeline: flushed by reset so in-flight responses are dropped.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                valid_q[i] <= 1'b0;
            end
        end else begin
            valid_q[0] <= valid_i;
            for (int i = 1; i < int'(DEPTH); i++) begin
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    // Payload pipeline, shifted in lockstep with the valids.
    always_ff @(posedge clk_i) begin
        data_q[0] <= data_i;
        for (int i = 1; i < int'(DEPTH); i++) begin
            data_q[i] <= data_q[i-1];
        end
    end

    assign valid_o = valid_q[DEPTH-1];
    assign data_o  = data_q[DEPTH-1];

endmodule

// File: rtl/rv32imf_obi_mem_responder.sv
// Memory-side responder for a req/gnt/rvalid port: word SRAM with byte-enable
// writes, programmable grant stall, bounded outstanding count and fixed latency.
module rv32imf_obi_mem_responder
    import rv32imf_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 16,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int unsigned GNT_STALL       = 0,
    parameter int unsigned RESP_LATENCY    = 1,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int unsigned Depth    = 2 ** (ADDR_WIDTH - 2);
    localparam logic [3:0]  StallMax = 4'(GNT_STALL);
    localparam logic [3:0]  OutMax   = 4'(MAX_OUTSTANDING);

    logic [3:0]  stall_cnt_q, stall_cnt_d;
    logic [3:0]  outst_q, outst_d;
    logic [31:0] mem_q [Depth];

    logic [31:0]           offset;
    logic                  in_range;
    logic [ADDR_WIDTH-3:0] word_idx;
    logic                  retire;
    mem_resp_t             resp_in;
    mem_resp_t             resp_out;

    // Range check on the offset so BASE_ADDR + size never needs to be formed.
    always_comb begin
        offset   = addr_i - BASE_ADDR;
        in_range = (addr_i >= BASE_ADDR) && ((offset >> ADDR_WIDTH) == 32'd0);
        word_idx = offset[ADDR_WIDTH-1:2];
    end

    // Grant once the stall has elapsed and a response slot is (or becomes) free.
    always_comb begin
        gnt_o = req_i && (stall_cnt_q == StallMax) && ((outst_q < OutMax) || retire);
    end

    // Stall counter and outstanding counter next-state.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!req_i || gnt_o) begin
            stall_cnt_d = 4'd0;
        end else if (stall_cnt_q != StallMax) begin
            stall_cnt_d = stall_cnt_q + 4'd1;
        end

        outst_d = outst_q;
        if (gnt_o && !retire) begin
            outst_d = outst_q + 4'd1;
        end else if (!gnt_o && retire && (outst_q != 4'd0)) begin
            outst_d = outst_q - 4'd1;
        end
    end

    // Control state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= 4'd0;
            outst_q     <= 4'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            outst_q     <= outst_d;
        end
    end

    // Byte-enable write port; array contents survive reset.
    always_ff @(posedge clk_i) begin
        if (gnt_o && we_i && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[word_idx][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Response payload captured at the grant edge.
    always_comb begin
        resp_in.err = !in_range;
        if (we_i) begin
            resp_in.rdata = 32'd0;
        end else if (in_range) begin
            resp_in.rdata = mem_q[word_idx];
        end else begin
            resp_in.rdata = RDATA_OOR;
        end
    end

    rv32imf_resp_delay_line #(
        .DEPTH (RESP_LATENCY),
        .T     (mem_resp_t)
    ) u_delay (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (gnt_o),
        .data_i  (resp_in),
        .valid_o (retire),
        .data_o  (resp_out)
    );

    // Response outputs are zeroed whenever no response is being presented.
    always_comb begin
        rvalid_o = retire;
        rdata_o  = retire ? resp_out.rdata : 32'd0;
        err_o    = retire && resp_out.err;
    end

endmodule
